urv_dm_responder: RTL and testbench
===================================

URV_DM_RESPONDER -- requirements
Module: urv_dm_responder

Interface
REQ-001 Parameters SHALL be: MEM_WORDS, 16384, data RAM depth in 32-bit words (power of 2); WAIT_CYCLES, 0, extra wait states per access (0..15); CONSOLE_ADDR, 'h100000, console byte port; STATUS_ADDR, 'h100004, test status port; FIFO_DEPTH, 16, console FIFO entries (power of 2).
REQ-002 Ports SHALL be as follows, one clock; reset is asynchronous and active-high:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous active-high reset
- dm_addr_i  in  32  byte address from CPU
- dm_data_s_i  in  32  store data
- dm_data_select_i  in  4  byte-lane enables
- dm_store_i  in  1  store request
- dm_load_i  in  1  load request
- dm_data_l_o  out  32  load data
- dm_load_done_o  out  1  load complete pulse
- dm_store_done_o  out  1  store complete pulse
- dm_ready_o  out  1  responder accepts a request this cycle
- con_data_o  out  8  console byte, FIFO head
- con_valid_o  out  1  console byte available
- con_ready_i  in  1  console sink pops head when con_valid_o high
- test_done_o  out  1  sticky test-complete flag
- test_result_o  out  32  last value written to STATUS_ADDR

Function
REQ-003 FSM SHALL have states IDLE, WAIT, DONE; dm_ready_o SHALL be 1 only in IDLE.
REQ-004 In IDLE, dm_store_i or dm_load_i high SHALL capture addr, data, select, and direction, load the wait counter with WAIT_CYCLES, and enter WAIT.
REQ-005 If dm_store_i and dm_load_i are both high, the store SHALL be taken and the load ignored (no dm_load_done_o).
REQ-006 WAIT SHALL decrement the counter each cycle and commit the access in the cycle the counter is 0, then enter DONE.
REQ-007 DONE SHALL assert exactly one of dm_load_done_o/dm_store_done_o for exactly one cycle, then return to IDLE; done SHALL occur WAIT_CYCLES+2 cycles after the request cycle.
REQ-008 dm_data_l_o SHALL be valid in the DONE cycle of a load and hold until the next load commits.
REQ-009 RAM index SHALL be dm_addr_i[31:2] modulo MEM_WORDS; addresses alias, and dm_addr_i[1:0] is ignored.
REQ-010 Stores SHALL write only lanes with dm_data_select_i[n]=1 (lane n = bits 8n+7:8n); select=0 SHALL complete with no write.
REQ-011 Store to CONSOLE_ADDR SHALL push dm_data_s_i[7:0] into the FIFO and SHALL NOT write RAM.
REQ-012 If the FIFO is full at commit, the FSM SHALL stay in WAIT (no done) until a pop frees space, then push and proceed; simultaneous pop and push on a full FIFO SHALL succeed in the same cycle.
REQ-013 con_valid_o SHALL be 1 when the FIFO is non-empty; con_data_o SHALL present the oldest byte; pop occurs when con_valid_o and con_ready_i are both high.
REQ-014 Store to STATUS_ADDR SHALL set test_done_o (sticky until reset), latch test_result_o from the full 32-bit data ignoring select, and SHALL NOT write RAM.
REQ-015 Load from CONSOLE_ADDR SHALL return the FIFO occupancy zero-extended; load from STATUS_ADDR SHALL return {test_result_o[31:1], test_done_o}.
REQ-016 Requests while not in IDLE SHALL be ignored; the CPU holds them until dm_ready_o is high.

Reset
REQ-017 On rst_i: FSM=IDLE; dm_ready_o=1; dm_load_done_o=0; dm_store_done_o=0; dm_data_l_o=0; FIFO emptied; con_valid_o=0; con_data_o=0; test_done_o=0; test_result_o=0; counter=0.
REQ-018 Reset during WAIT SHALL abandon the access with no RAM write, no FIFO push, and no done pulse; RAM contents SHALL NOT be reset.

Verification
REQ-019 WAIT_CYCLES=0, store 'hDEADBEEF to 'h10 with select 'hF, then load 'h10 -> store_done 2 cycles after the request; load_done with dm_data_l_o='hDEADBEEF.
REQ-020 Store 'h000000AA to 'h10 with select 'b0001 over 'hDEADBEEF -> load returns 'hDEADBEAA; load 'h10+4*MEM_WORDS -> same value (alias).
REQ-021 WAIT_CYCLES=3, load -> dm_ready_o low for 5 cycles; done 5 cycles after the request.
REQ-022 con_ready_i=0, 17 stores to 'h100000 -> 16th completes, 17th stalls with no done; one pop -> 17th completes; load 'h100000 returns 16.
REQ-023 Store 'h00000001 to 'h100004 -> test_done_o=1, test_result_o=1; load 'h100004 returns 1.
REQ-024 Assert rst_i mid-WAIT of a store to 'h20 -> no store_done; RAM word 'h20 unchanged; all outputs at reset values.

Source files
------------

// File: rtl/urv_dm_responder.sv
// Data-memory responder for a small RISC-V core: word RAM with byte lanes,
// programmable wait states, a console byte FIFO and a sticky test-status port.
//
// state | meaning
// IDLE  | ready, accepts one load or store request
// WAIT  | counts wait states down, commits the access when the counter is 0
// DONE  | one-cycle completion pulse, then back to IDLE
module urv_dm_responder #(
  parameter int          MEM_WORDS    = 16384,
  parameter int          WAIT_CYCLES  = 0,
  parameter logic [31:0] CONSOLE_ADDR = 32'h0010_0000,
  parameter logic [31:0] STATUS_ADDR  = 32'h0010_0004,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_ready_o,
  output logic [7:0]  con_data_o,
  output logic        con_valid_o,
  input  logic        con_ready_i,
  output logic        test_done_o,
  output logic [31:0] test_result_o
);
  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          FW        = $clog2(FIFO_DEPTH);
  localparam logic [FW:0] FIFO_FULL = (FW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_sel;
  logic          r_is_store;
  logic          r_ready;
  logic          r_load_done;
  logic          r_store_done;
  logic [31:0]   r_load_data;
  logic          r_test_done;
  logic [31:0]   r_test_result;

  logic [31:0]   r_mem [MEM_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [FW-1:0] r_rd_ptr;
  logic [FW-1:0] r_wr_ptr;
  logic [FW:0]   r_count;

  logic [AW-1:0] w_idx;
  logic          w_is_console;
  logic          w_is_status;
  logic          w_commit;
  logic          w_pop;
  logic          w_push;
  logic          w_stall;
  logic          w_ram_we;

  assign w_idx        = r_addr[AW+1:2];
  assign w_is_console = (r_addr == CONSOLE_ADDR);
  assign w_is_status  = (r_addr == STATUS_ADDR);
  assign w_commit     = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_pop        = (r_count != '0) && con_ready_i;
  // A full FIFO still accepts the push when the sink pops in the same cycle.
  assign w_push       = w_commit && r_is_store && w_is_console &&
                        ((r_count != FIFO_FULL) || w_pop);
  assign w_stall      = w_commit && r_is_store && w_is_console && !w_push;
  assign w_ram_we     = w_commit && r_is_store && !w_is_console && !w_is_status;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_sel         <= 4'd0;
      r_is_store    <= 1'b0;
      r_ready       <= 1'b1;
      r_load_done   <= 1'b0;
      r_store_done  <= 1'b0;
      r_load_data   <= 32'd0;
      r_test_done   <= 1'b0;
      r_test_result <= 32'd0;
    end else begin
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dm_store_i || dm_load_i) begin
            r_addr     <= dm_addr_i;
            r_wdata    <= dm_data_s_i;
            r_sel      <= dm_data_select_i;
            r_is_store <= dm_store_i;
            r_cnt      <= WAIT_LOAD;
            r_ready    <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!w_stall) begin
            if (r_is_store) begin
              r_store_done <= 1'b1;
              if (w_is_status) begin
                r_test_done   <= 1'b1;
                r_test_result <= r_wdata;
              end
            end else begin
              r_load_done <= 1'b1;
              if (w_is_console)
                r_load_data <= {{(31-FW){1'b0}}, r_count};
              else if (w_is_status)
                r_load_data <= {r_test_result[31:1], r_test_done};
              else
                r_load_data <= r_mem[w_idx];
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_ram_we) begin
      for (int n = 0; n < 4; n++) begin
        if (r_sel[n]) r_mem[w_idx][8*n +: 8] <= r_wdata[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= r_wdata[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dm_data_l_o     = r_load_data;
  assign dm_load_done_o  = r_load_done;
  assign dm_store_done_o = r_store_done;
  assign dm_ready_o      = r_ready;
  assign con_valid_o     = (r_count != '0);
  assign con_data_o      = (r_count != '0) ? r_fifo[r_rd_ptr] : 8'h00;
  assign test_done_o     = r_test_done;
  assign test_result_o   = r_test_result;

endmodule

// File: tb/tb_urv_dm_responder.sv
// Bench for urv_dm_responder: transaction-level model with a per-cycle compare,
// plus directed accesses with hand-computed results on a 0- and a 3-wait-state instance.
module tb_urv_dm_responder;
  localparam int          MW    = 16384;
  localparam int          DEPTH = 16;
  localparam int          W0    = 0;
  localparam logic [31:0] CON   = 32'h0010_0000;
  localparam logic [31:0] STAT  = 32'h0010_0004;

  logic        clk;
  logic        rst;
  logic [31:0] addr, wdata, dl, tr;
  logic [3:0]  sel;
  logic        st, ld, ld_done, sd_done, ready, cv, con_rdy, td;
  logic [7:0]  cd;

  logic [31:0] a3, d3, dl3, tr3;
  logic [3:0]  sel3;
  logic        st3, ld3, ld_done3, sd_done3, ready3, cv3, con_rdy3, td3;
  logic [7:0]  cd3;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 0;

  urv_dm_responder #(.WAIT_CYCLES(W0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .dm_addr_i(addr), .dm_data_s_i(wdata),
    .dm_data_select_i(sel), .dm_store_i(st), .dm_load_i(ld),
    .dm_data_l_o(dl), .dm_load_done_o(ld_done), .dm_store_done_o(sd_done),
    .dm_ready_o(ready), .con_data_o(cd), .con_valid_o(cv), .con_ready_i(con_rdy),
    .test_done_o(td), .test_result_o(tr));

  urv_dm_responder #(.WAIT_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .dm_addr_i(a3), .dm_data_s_i(d3),
    .dm_data_select_i(sel3), .dm_store_i(st3), .dm_load_i(ld3),
    .dm_data_l_o(dl3), .dm_load_done_o(ld_done3), .dm_store_done_o(sd_done3),
    .dm_ready_o(ready3), .con_data_o(cd3), .con_valid_o(cv3), .con_ready_i(con_rdy3),
    .test_done_o(td3), .test_result_o(tr3));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  // Model of the 0-wait-state instance: an accepted request is due WAIT+1
  // edges later, a console store to a full FIFO waits for a pop.
  int          cyc = 0;
  bit          m_busy, m_done_pend, m_st;
  logic [31:0] m_a, m_d, m_w;
  logic [3:0]  m_s;
  int          m_due, m_occ, m_idx;
  bit          m_pop;
  logic [31:0] mram [int];
  logic [7:0]  mfifo [$];
  bit          e_ready, e_ld, e_sd, e_dknown, e_tdone;
  logic [31:0] e_data, e_tres;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done_pend = 0;
      e_ready = 1; e_ld = 0; e_sd = 0; e_dknown = 1; e_data = 0;
      e_tdone = 0; e_tres = 0;
      mfifo.delete();
    end else begin
      cyc++;
      m_occ = mfifo.size();
      m_pop = (m_occ != 0) && con_rdy;
      if (m_pop) void'(mfifo.pop_front());
      e_ld = 0; e_sd = 0;
      if (m_done_pend) begin
        m_done_pend = 0;
        m_busy = 0;
      end else if (m_busy) begin
        if (cyc >= m_due && !(m_st && m_a == CON && m_occ == DEPTH && !m_pop)) begin
          m_idx = int'(m_a[31:2]) % MW;
          if (m_st) begin
            e_sd = 1;
            if (m_a == CON) mfifo.push_back(m_d[7:0]);
            else if (m_a == STAT) begin e_tdone = 1; e_tres = m_d; end
            else begin
              m_w = mram.exists(m_idx) ? mram[m_idx] : 32'h0;
              for (int n = 0; n < 4; n++) if (m_s[n]) m_w[8*n +: 8] = m_d[8*n +: 8];
              mram[m_idx] = m_w;
            end
          end else begin
            e_ld = 1; e_dknown = 1;
            if (m_a == CON) e_data = 32'(m_occ);
            else if (m_a == STAT) e_data = {e_tres[31:1], e_tdone};
            else if (mram.exists(m_idx)) e_data = mram[m_idx];
            else e_dknown = 0;
          end
          m_done_pend = 1;
        end
      end else if (st || ld) begin
        m_busy = 1; m_st = st; m_a = addr; m_d = wdata; m_s = sel;
        m_due = cyc + W0 + 1;
      end
      e_ready = !m_busy;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("ready", ready, e_ready);
      chk("load_done", ld_done, e_ld);
      chk("store_done", sd_done, e_sd);
      if (e_dknown) chk("load_data", dl, e_data);
      chk("con_valid", cv, mfifo.size() != 0);
      chk("con_data", cd, (mfifo.size() != 0) ? mfifo[0] : 8'h00);
      chk("test_done", td, e_tdone);
      chk("test_result", tr, e_tres);
    end
  end

  task automatic start_req(input bit s, input bit l, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] se);
    int t;
    @(negedge clk);
    addr = a; wdata = d; sel = se; st = s; ld = l;
    t = 0;
    while (!ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("req_accept", ready, 1);
    @(negedge clk);
    st = 0; ld = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!(ld_done || sd_done) && lat < 100) begin @(negedge clk); lat++; end
    if (lat >= 100) chk("done_timeout", ld_done | sd_done, 1);
  endtask

  task automatic acc3(input bit s, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output int low);
    @(negedge clk);
    a3 = a; d3 = d; sel3 = 4'hF; st3 = s; ld3 = !s;
    @(negedge clk);
    st3 = 0; ld3 = 0; lat = 1; low = ready3 ? 0 : 1;
    while (!(ld_done3 || sd_done3) && lat < 50) begin
      @(negedge clk); lat++;
      if (!ready3) low++;
    end
  endtask

  initial begin
    int lat, low;
    rst = 1; addr = 0; wdata = 0; sel = 0; st = 0; ld = 0; con_rdy = 0;
    a3 = 0; d3 = 0; sel3 = 0; st3 = 0; ld3 = 0; con_rdy3 = 0;
    repeat (3) @(negedge clk);
    rst = 0; cmp_en = 1;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_load_data", dl, 0);
    chk("rst_con_valid", cv, 0);
    chk("rst_test_result", tr, 0);
    chk("rst3_ready", ready3, 1);

    // full-word store then load, zero wait states
    start_req(1, 0, 32'h10, 32'hDEADBEEF, 4'hF); wait_done(lat);
    chk("st_latency", lat, 2); chk("st_done", sd_done, 1);
    start_req(0, 1, 32'h10, 0, 0); wait_done(lat);
    chk("ld_latency", lat, 2); chk("ld_data", dl, 32'hDEADBEEF);

    // byte lane, alias, ignored low address bits, empty select
    start_req(1, 0, 32'h10, 32'h000000AA, 4'b0001); wait_done(lat);
    start_req(0, 1, 32'h10, 0, 0); wait_done(lat);
    chk("lane0_data", dl, 32'hDEADBEAA);
    start_req(0, 1, 32'h10 + 4*MW, 0, 0); wait_done(lat);
    chk("alias_data", dl, 32'hDEADBEAA);
    start_req(1, 0, 32'h13, 32'h55555555, 4'b0000); wait_done(lat);
    chk("sel0_done", sd_done, 1);
    start_req(0, 1, 32'h13, 0, 0); wait_done(lat);
    chk("sel0_data", dl, 32'hDEADBEAA);

    // simultaneous store and load: the store wins
    start_req(1, 1, 32'h30, 32'h0BADF00D, 4'hF); wait_done(lat);
    chk("both_store_done", sd_done, 1); chk("both_load_done", ld_done, 0);
    start_req(0, 1, 32'h30, 0, 0); wait_done(lat);
    chk("both_data", dl, 32'h0BADF00D);

    // three wait states
    acc3(1, 32'h40, 32'hCAFEF00D, lat, low);
    chk("w3_st_latency", lat, 5); chk("w3_st_ready_low", low, 5);
    @(negedge clk); chk("w3_ready_back", ready3, 1);
    acc3(0, 32'h40, 0, lat, low);
    chk("w3_ld_latency", lat, 5); chk("w3_ld_ready_low", low, 5);
    chk("w3_ld_data", dl3, 32'hCAFEF00D);

    start_req(1, 0, 32'h20, 32'h11223344, 4'hF); wait_done(lat);

    // console FIFO fill, stall on full, release by one pop
    con_rdy = 0;
    for (int i = 0; i < 16; i++) begin
      start_req(1, 0, CON, 32'h40 + i, 4'h1); wait_done(lat);
    end
    chk("con_16th_latency", lat, 2);
    start_req(1, 0, CON, 32'h50, 4'h1);
    for (int k = 0; k < 8; k++) begin
      chk("full_no_done", sd_done, 0); chk("full_busy", ready, 0);
      @(negedge clk);
    end
    con_rdy = 1; @(negedge clk); con_rdy = 0;
    chk("con_17th_done", sd_done, 1);
    chk("con_head", cd, 8'h41);
    start_req(0, 1, CON, 0, 0); wait_done(lat);
    chk("con_occupancy", dl, 16);
    con_rdy = 1; repeat (16) @(negedge clk); con_rdy = 0;
    chk("con_drained", cv, 0);

    // status port
    start_req(1, 0, STAT, 32'h1, 4'hF); wait_done(lat);
    chk("stat_done", td, 1); chk("stat_result", tr, 1);
    start_req(0, 1, STAT, 0, 0); wait_done(lat);
    chk("stat_load", dl, 1);
    start_req(1, 0, STAT, 32'h12345678, 4'h0); wait_done(lat);
    chk("stat_result_nosel", tr, 32'h12345678);
    start_req(0, 1, STAT, 0, 0); wait_done(lat);
    chk("stat_load2", dl, 32'h12345679);

    // reset in the middle of a store
    start_req(1, 0, CON, 32'h7E, 4'h1); wait_done(lat);
    start_req(1, 0, 32'h20, 32'hFFFFFFFF, 4'hF);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_no_done", sd_done, 0);
    chk("rst_mid_ready", ready, 1);
    chk("rst_mid_ld_done", ld_done, 0);
    chk("rst_mid_data", dl, 0);
    chk("rst_mid_con_valid", cv, 0);
    chk("rst_mid_con_data", cd, 0);
    chk("rst_mid_test_done", td, 0);
    chk("rst_mid_test_result", tr, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_after_no_done", sd_done, 0);
    start_req(0, 1, 32'h20, 0, 0); wait_done(lat);
    chk("rst_ram_kept", dl, 32'h11223344);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
